adc_spi_responder: RTL

- Synthesizable emulator of the DE1-SoC LTC2308 serial ADC, seen from the ADC pins.
- Responds to ADC_CS_N, ADC_SCLK and ADC_DIN by driving ADC_DOUT with 12-bit results. The values come from a parallel 8-channel source: the test sine generator, constants, or a capture buffer.
- Lets the oscilloscope's ADC master, sample buffers and VGA trace path be exercised on the board and in simulation without analog hardware.
- Implements the LTC2308 pipelined rule: the config word shifted in during frame N selects the data returned in frame N+1.

---
 rtl/adc_emu_pkg.sv | 21 ++
 rtl/adc_pin_sync.sv | 32 +++
 rtl/adc_spi_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/adc_emu_pkg.sv
// Shared types and config-word helpers for the LTC2308 pin-level emulator.
// Pure declarations: no latency, no flow control.
package adc_emu_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  localparam logic [5:0] RESET_CFG = 6'b100010;

  // Single-ended channel number is {S1, S0, O/S}, not the field order in the word.
  function automatic logic [2:0] cfg_to_channel(input logic [5:0] cfg);
    return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
  endfunction

endpackage

// File: rtl/adc_pin_sync.sv
// Synchronizes one asynchronous ADC pin and flags its edges.
// Level valid SYNC_STAGES clocks after the pin; rise/fall one clock wide; no backpressure.
module adc_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// LTC2308 emulator: answers CS_N/SCLK/DIN with 12-bit samples; config from frame N selects frame N+1.
// Pin edge to action SYNC_STAGES+1 clocks; the SPI master paces everything, no backpressure.
module adc_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter int         NUM_BITS    = 12,
  parameter int         CFG_BITS    = 6,
  parameter logic [5:0] RESET_CFG   = adc_emu_pkg::RESET_CFG
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [8*NUM_BITS-1:0] ch_data,
  input  logic                  ADC_CS_N,
  input  logic                  ADC_SCLK,
  input  logic                  ADC_DIN,
  output logic                  ADC_DOUT,
  output logic [CFG_BITS-1:0]   active_cfg,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic [15:0]           frame_count
);
  import adc_emu_pkg::*;

  localparam int BW = $clog2(NUM_BITS + 1);
  localparam int CW = $clog2(CFG_BITS + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS);
  localparam logic [CW-1:0] CFG_LAST = CW'(CFG_BITS);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic din, din_rise, din_fall;
  logic unused_sync;

  // Reset values match an idle bus so release of reset never fakes an edge.
  adc_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clock(clock), .reset_n(reset_n), .pin(ADC_CS_N),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  adc_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clock(clock), .reset_n(reset_n), .pin(ADC_SCLK),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  adc_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_din (
    .clock(clock), .reset_n(reset_n), .pin(ADC_DIN),
    .level(din), .rise(din_rise), .fall(din_fall));

  assign unused_sync = &{1'b0, cs_lvl, sclk_lvl, din_rise, din_fall};

  state_t                state, state_d;
  logic [NUM_BITS-1:0]   shift_reg, shift_d;
  logic [BW-1:0]         bit_cnt, bit_d;
  logic [CW-1:0]         cfg_cnt, cfg_cnt_d;
  logic [CFG_BITS-1:0]   cfg_shift, cfg_shift_d, active_d;
  logic                  dout_q, dout_d, done_d, abort_d;
  logic [15:0]           frame_count_q, count_d;
  logic [2:0]            ch;
  logic [NUM_BITS-1:0]   raw, sample_result;

  assign ch  = cfg_to_channel(active_cfg);
  assign raw = ch_data[ch*NUM_BITS +: NUM_BITS];

  always_comb begin
    sample_result = raw;
    if (!active_cfg[CFG_SD] || active_cfg[CFG_SLP])
      sample_result = '0;
    else if (!active_cfg[CFG_UNI])
      sample_result[NUM_BITS-1] = ~raw[NUM_BITS-1];
  end

  always_comb begin
    state_d     = state;
    shift_d     = shift_reg;
    bit_d       = bit_cnt;
    cfg_cnt_d   = cfg_cnt;
    cfg_shift_d = cfg_shift;
    active_d    = active_cfg;
    dout_d      = dout_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    count_d     = frame_count_q;
    case (state)
      IDLE: begin
        dout_d = 1'b0;
        if (cs_fall) begin
          shift_d   = sample_result;
          dout_d    = sample_result[NUM_BITS-1];
          bit_d     = '0;
          cfg_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // CS_N rising in the same clock as an SCLK edge takes priority.
        if (cs_rise) begin
          abort_d = 1'b1;
          dout_d  = 1'b0;
          if (cfg_cnt == CFG_LAST) active_d = cfg_shift;
          state_d = IDLE;
        end else begin
          if (sclk_rise && cfg_cnt < CFG_LAST) begin
            cfg_shift_d = {cfg_shift[CFG_BITS-2:0], din};
            cfg_cnt_d   = cfg_cnt + CW'(1);
          end
          if (sclk_fall) begin
            bit_d   = bit_cnt + BW'(1);
            shift_d = shift_reg << 1;
            if (bit_d == BIT_LAST) begin
              dout_d  = 1'b0;
              state_d = TAIL;
            end else begin
              dout_d = shift_reg[NUM_BITS-2];
            end
          end
        end
      end
      TAIL: begin
        dout_d = 1'b0;
        if (cs_rise) begin
          active_d = cfg_shift;
          done_d   = 1'b1;
          count_d  = frame_count_q + 16'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      shift_reg     <= '0;
      bit_cnt       <= '0;
      cfg_cnt       <= '0;
      cfg_shift     <= '0;
      active_cfg    <= RESET_CFG;
      dout_q        <= 1'b0;
      frame_done    <= 1'b0;
      frame_abort   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state         <= state_d;
      shift_reg     <= shift_d;
      bit_cnt       <= bit_d;
      cfg_cnt       <= cfg_cnt_d;
      cfg_shift     <= cfg_shift_d;
      active_cfg    <= active_d;
      dout_q        <= dout_d;
      frame_done    <= done_d;
      frame_abort   <= abort_d;
      frame_count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && cs_fall) assert (state == IDLE);
  end

  assign ADC_DOUT    = dout_q;
  assign frame_count = frame_count_q;

endmodule
